// File: rtl/nv_nvdla_csb_pkg.sv
// Shared CSB definitions: packet widths, field positions and the
// "does this request produce a response" decode.
package nv_nvdla_csb_pkg;

  localparam int REQ_PD_W     = 63;
  localparam int RESP_PD_W    = 34;
  localparam int WRITE_BIT    = 54;
  localparam int NPOSTED_BIT  = 55;
  localparam int RESP_ERR_BIT = 32;
  localparam int RESP_WR_BIT  = 33;

  // Reads and non-posted writes both come back with a response.
  function automatic logic need_resp(input logic [REQ_PD_W-1:0] pd);
    return ~pd[WRITE_BIT] | pd[NPOSTED_BIT];
  endfunction

endpackage

// File: rtl/nv_nvdla_csb_arb_idfifo.sv
// In-order owner-ID FIFO (DEPTH x 1 bit) for the CSB arbiter: remembers which
// master each outstanding response-bearing request belongs to.
module nv_nvdla_csb_arb_idfifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     push_id,
  input  logic                     pop,
  output logic                     pop_id,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign pop_id  = mem[rd_ptr];

  // Power-of-two depth lets the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_id;
  end

endmodule

// File: rtl/nv_nvdla_csb_arb.sv
// Two-master CSB arbiter onto one registered slave port, with in-order
// response routing. Build option: NVDLA_CSB_ARB_STRICT_PRIO_EN (m0 always wins).
module nv_nvdla_csb_arb
  import nv_nvdla_csb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  nvdla_core_clk,
  input  logic                  nvdla_core_rstn,
  input  logic                  m0_req_pvld,
  output logic                  m0_req_prdy,
  input  logic [REQ_PD_W-1:0]   m0_req_pd,
  output logic                  m0_resp_valid,
  output logic [RESP_PD_W-1:0]  m0_resp_pd,
  input  logic                  m1_req_pvld,
  output logic                  m1_req_prdy,
  input  logic [REQ_PD_W-1:0]   m1_req_pd,
  output logic                  m1_resp_valid,
  output logic [RESP_PD_W-1:0]  m1_resp_pd,
  output logic                  slv_req_pvld,
  input  logic                  slv_req_prdy,
  output logic [REQ_PD_W-1:0]   slv_req_pd,
  input  logic                  slv_resp_valid,
  input  logic [RESP_PD_W-1:0]  slv_resp_pd,
  output logic                  arb_resp_orphan
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic                need0, need1;
  logic                elig0, elig1;
  logic                gnt0, gnt1;
  logic                slot_free;
  logic [REQ_PD_W-1:0] gnt_pd;
  logic                fifo_push, fifo_pop, fifo_pop_id;
  logic                fifo_empty, fifo_full;
  logic [CW-1:0]       fifo_count;

  assign need0     = need_resp(m0_req_pd);
  assign need1     = need_resp(m1_req_pd);
  assign slot_free = ~slv_req_pvld | slv_req_prdy;
  // Eligibility uses the pre-pop count: a full FIFO blocks even in a pop cycle.
  assign elig0     = m0_req_pvld & (~need0 | (fifo_count < CW'(DEPTH)));
  assign elig1     = m1_req_pvld & (~need1 | (fifo_count < CW'(DEPTH)));

`ifdef NVDLA_CSB_ARB_STRICT_PRIO_EN
  always_comb begin
    gnt0 = slot_free & elig0;
    gnt1 = slot_free & elig1 & ~elig0;
  end
`else
  logic last_gnt;

  always_comb begin
    gnt0 = slot_free & elig0 & (~elig1 | last_gnt);
    gnt1 = slot_free & elig1 & (~elig0 | ~last_gnt);
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)  last_gnt <= 1'b1;
    else if (gnt0 | gnt1)  last_gnt <= gnt1;
  end
`endif

  assign m0_req_prdy = gnt0;
  assign m1_req_prdy = gnt1;
  assign gnt_pd      = gnt1 ? m1_req_pd : m0_req_pd;
  assign fifo_push   = ((gnt0 & need0) | (gnt1 & need1)) & ~fifo_full;
  assign fifo_pop    = slv_resp_valid & ~fifo_empty;

  nv_nvdla_csb_arb_idfifo #(.DEPTH(DEPTH)) u_idfifo (
    .clk     (nvdla_core_clk),
    .rst_n   (nvdla_core_rstn),
    .push    (fifo_push),
    .push_id (gnt1),
    .pop     (fifo_pop),
    .pop_id  (fifo_pop_id),
    .count   (fifo_count),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      slv_req_pvld <= 1'b0;
      slv_req_pd   <= '0;
    end else if (gnt0 | gnt1) begin
      slv_req_pvld <= 1'b1;
      slv_req_pd   <= gnt_pd;
    end else if (slv_req_prdy) begin
      slv_req_pvld <= 1'b0;
    end
  end

  // Response routing: one-cycle pulse to the recorded owner, pd held otherwise.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      m0_resp_valid   <= 1'b0;
      m1_resp_valid   <= 1'b0;
      m0_resp_pd      <= '0;
      m1_resp_pd      <= '0;
      arb_resp_orphan <= 1'b0;
    end else begin
      m0_resp_valid <= fifo_pop & ~fifo_pop_id;
      m1_resp_valid <= fifo_pop & fifo_pop_id;
      if (fifo_pop & ~fifo_pop_id) m0_resp_pd <= slv_resp_pd;
      if (fifo_pop & fifo_pop_id)  m1_resp_pd <= slv_resp_pd;
      if (slv_resp_valid & fifo_empty) arb_resp_orphan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nv_nvdla_csb_arb.sv
// Self-checking bench for nv_nvdla_csb_arb: queue-based reference model plus
// directed literal scenarios and randomized traffic.
module tb_nv_nvdla_csb_arb;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rstn;
  logic        m0v, m1v;
  logic [62:0] m0pd, m1pd;
  logic        m0_req_prdy, m1_req_prdy;
  logic        m0_resp_valid, m1_resp_valid;
  logic [33:0] m0_resp_pd, m1_resp_pd;
  logic        slv_req_pvld;
  logic        slv_prdy;
  logic [62:0] slv_req_pd;
  logic        slv_rv;
  logic [33:0] slv_rpd;
  logic        arb_resp_orphan;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          q[$];
  bit          last;
  bit          sv;
  logic [62:0] spd;
  bit          rv0, rv1;
  logic [33:0] rpd0, rpd1;
  bit          orph;
  bit          g0, g1;

  nv_nvdla_csb_arb #(.DEPTH(DEPTH)) dut (
    .nvdla_core_clk  (clk),
    .nvdla_core_rstn (rstn),
    .m0_req_pvld     (m0v),
    .m0_req_prdy     (m0_req_prdy),
    .m0_req_pd       (m0pd),
    .m0_resp_valid   (m0_resp_valid),
    .m0_resp_pd      (m0_resp_pd),
    .m1_req_pvld     (m1v),
    .m1_req_prdy     (m1_req_prdy),
    .m1_req_pd       (m1pd),
    .m1_resp_valid   (m1_resp_valid),
    .m1_resp_pd      (m1_resp_pd),
    .slv_req_pvld    (slv_req_pvld),
    .slv_req_prdy    (slv_prdy),
    .slv_req_pd      (slv_req_pd),
    .slv_resp_valid  (slv_rv),
    .slv_resp_pd     (slv_rpd),
    .arb_resp_orphan (arb_resp_orphan)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit nr(input logic [62:0] pd);
    return !pd[54] || pd[55];
  endfunction

  function automatic logic [62:0] rand_pd();
    logic [62:0] pd;
    int kind;
    pd = {31'($urandom), 32'($urandom)};
    kind = $urandom_range(0, 2);
    pd[54] = (kind != 0);
    pd[55] = (kind == 2);
    return pd;
  endfunction

  function automatic logic [62:0] mk_pd(input logic [21:0] addr, input bit wr, input bit np);
    logic [62:0] pd;
    pd = '0;
    pd[21:0] = addr;
    pd[54]   = wr;
    pd[55]   = np;
    return pd;
  endfunction

  // One clock: inputs are already set at the negedge; compare, then advance model.
  task automatic step();
    bit sf, e0, e1;
    int w, id;
    #1;
    sf = !sv || slv_prdy;
    e0 = m0v && (!nr(m0pd) || q.size() < DEPTH);
    e1 = m1v && (!nr(m1pd) || q.size() < DEPTH);
    w = -1;
    if (sf) begin
      if (e0 && e1) begin
`ifdef NVDLA_CSB_ARB_STRICT_PRIO_EN
        w = 0;
`else
        w = last ? 0 : 1;
`endif
      end else if (e0) w = 0;
      else if (e1) w = 1;
    end
    g0 = (w == 0);
    g1 = (w == 1);
    chk("m0_req_prdy", m0_req_prdy, g0);
    chk("m1_req_prdy", m1_req_prdy, g1);
    chk("slv_req_pvld", slv_req_pvld, sv);
    chk("slv_req_pd", slv_req_pd, spd);
    chk("m0_resp_valid", m0_resp_valid, rv0);
    chk("m1_resp_valid", m1_resp_valid, rv1);
    chk("m0_resp_pd", m0_resp_pd, rpd0);
    chk("m1_resp_pd", m1_resp_pd, rpd1);
    chk("arb_resp_orphan", arb_resp_orphan, orph);
    @(posedge clk);
    rv0 = 0;
    rv1 = 0;
    if (slv_rv) begin
      if (q.size() > 0) begin
        id = q.pop_front();
        if (id == 0) begin rv0 = 1; rpd0 = slv_rpd; end
        else         begin rv1 = 1; rpd1 = slv_rpd; end
      end else orph = 1;
    end
    if (w >= 0) begin
      sv   = 1;
      spd  = (w == 0) ? m0pd : m1pd;
      last = (w == 1);
      if (nr(spd)) q.push_back(w);
    end else if (slv_prdy) sv = 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    m0v = 0; m1v = 0; slv_rv = 0; slv_prdy = 1;
    rstn = 0;
    #1;
    chk("rst slv_req_pvld", slv_req_pvld, 0);
    chk("rst slv_req_pd", slv_req_pd, 0);
    chk("rst m0_resp_valid", m0_resp_valid, 0);
    chk("rst m1_resp_pd", m1_resp_pd, 0);
    chk("rst orphan", arb_resp_orphan, 0);
    @(posedge clk);
    @(posedge clk);
    q.delete();
    last = 1; sv = 0; spd = '0; rv0 = 0; rv1 = 0; rpd0 = '0; rpd1 = '0; orph = 0;
    @(negedge clk);
    rstn = 1;
  endtask

  task automatic drain();
    m0v = 0; m1v = 0; slv_prdy = 1;
    for (int i = 0; i < 64 && q.size() > 0; i++) begin
      slv_rv  = 1;
      slv_rpd = {2'($urandom_range(0, 3)), 32'($urandom)};
      step();
    end
    slv_rv = 0;
    step();
    chk("drain empty", q.size(), 0);
  endtask

  initial begin
    logic [62:0] pa, pb, hold;
    int resp_pct;
    rstn = 0; m0v = 0; m1v = 0; m0pd = '0; m1pd = '0;
    slv_prdy = 1; slv_rv = 0; slv_rpd = '0;
    @(negedge clk);
    do_reset();

    // Single read from m0
    m0v = 1; m0pd = mk_pd(22'h10, 0, 0);
    #1 chk("first tie-free prdy m0", m0_req_prdy, 1);
    step();
    chk("single slv_req_pvld", slv_req_pvld, 1);
    chk("single slv_req_pd", slv_req_pd, 63'h10);
    m0v = 0;
    step();
    step();
    slv_rv = 1; slv_rpd = {1'b0, 1'b0, 32'hA5A5_0001};
    step();
    slv_rv = 0;
    chk("single m0_resp_valid", m0_resp_valid, 1);
    chk("single m0_resp_pd", m0_resp_pd, 34'h0_A5A5_0001);
    chk("single m1_resp_valid", m1_resp_valid, 0);
    step();
    chk("single resp pulse", m0_resp_valid, 0);

    // Round-robin contention right after reset
    do_reset();
    pa = mk_pd(22'h1, 0, 0);
    pb = mk_pd(22'h2, 0, 0);
    m0v = 1; m0pd = pa; m1v = 1; m1pd = pb;
    for (int i = 0; i < 4; i++) begin
      step();
`ifdef NVDLA_CSB_ARB_STRICT_PRIO_EN
      chk("prio grant order", slv_req_pd, pa);
`else
      chk("rr grant order", slv_req_pd, (i % 2 == 0) ? pa : pb);
`endif
    end
    m0v = 0; m1v = 0;
    slv_rv = 1; slv_rpd = 34'h1_0000_0000;
    step();
    chk("rr first resp to m0", m0_resp_valid, 1);
    drain();

    // Backpressure: held slave request stays stable, nobody granted
    m0v = 1; m0pd = mk_pd(22'h33, 1, 1);
    step();
    hold = m0pd;
    m0pd = mk_pd(22'h34, 0, 0);
    m1v = 1; m1pd = mk_pd(22'h35, 1, 0);
    slv_prdy = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp m0_req_prdy", m0_req_prdy, 0);
      chk("bp m1_req_prdy", m1_req_prdy, 0);
      step();
      chk("bp slv_req_pd stable", slv_req_pd, hold);
    end
    slv_prdy = 1;
    #1 chk("bp resume", m0_req_prdy | m1_req_prdy, 1);
    step();
    m0v = 0; m1v = 0;
    drain();

    // FIFO full: m1 fills it, posted write from m0 still passes
    m1v = 1;
    for (int i = 0; i < 4; i++) begin
      m1pd = mk_pd(22'(i + 8'h40), 0, 0);
      step();
    end
    m1pd = mk_pd(22'h44, 0, 0);
    m0v = 1; m0pd = mk_pd(22'h50, 1, 0);
    #1;
    chk("full m1 stalled", m1_req_prdy, 0);
    chk("full m0 posted ok", m0_req_prdy, 1);
    step();
    m0v = 0;
    step();
    slv_rv = 1; slv_rpd = 34'h0_0000_0040;
    #1 chk("full pop-cycle still blocked", m1_req_prdy, 0);
    step();
    slv_rv = 0;
    #1 chk("full released", m1_req_prdy, 1);
    step();
    m1v = 0;
    drain();

    // Randomized traffic, with a mid-run reset
    for (int c = 0; c < 3000; c++) begin
      if (c == 1500) do_reset();
      resp_pct = ((c / 300) % 2 != 0) ? 15 : 60;
      if (!m0v && $urandom_range(0, 99) < 50) begin m0v = 1; m0pd = rand_pd(); end
      if (!m1v && $urandom_range(0, 99) < 50) begin m1v = 1; m1pd = rand_pd(); end
      slv_prdy = ($urandom_range(0, 99) < 75);
      slv_rv   = (q.size() > 0) && ($urandom_range(0, 99) < resp_pct);
      slv_rpd  = {2'($urandom_range(0, 3)), 32'($urandom)};
      step();
      if (g0) m0v = 0;
      if (g1) m1v = 0;
    end
    drain();

    // Non-posted write from m1, then an orphan response
    m1v = 1; m1pd = mk_pd(22'h77, 1, 1);
    step();
    m1v = 0;
    slv_rv = 1; slv_rpd = 34'h2_0000_0000;
    step();
    slv_rv = 0;
    chk("np write m1_resp_valid", m1_resp_valid, 1);
    chk("np write resp wr bit", m1_resp_pd[33], 1);
    slv_rv = 1; slv_rpd = 34'h0_DEAD_BEEF;
    step();
    slv_rv = 0;
    chk("orphan flag", arb_resp_orphan, 1);
    chk("orphan no m0 resp", m0_resp_valid, 0);
    chk("orphan no m1 resp", m1_resp_valid, 0);
    for (int i = 0; i < 3; i++) step();
    chk("orphan sticky", arb_resp_orphan, 1);
    do_reset();
    step();
    chk("orphan cleared by reset", arb_resp_orphan, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
